// File: rtl/kernel_convolve.sv
// 7x7 convolution stage: captures a window plus kernel/divisor, accumulates one
// row per cycle, normalises with a serial restoring divider and clamps to 0..255.
`timescale 1ns/1ps

module kernel_convolve #(
   parameter int ROWS     = 7,
   parameter int COLS     = 7,
   parameter int DIV_BITS = 21
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [ROWS*COLS*8-1:0]   kernel,
   input  logic [7:0]               divisor,
   input  logic [ROWS*COLS*8-1:0]   window,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic [7:0]               out_pixel,
   output logic                     out_valid,
   input  logic                     out_ready
);

   localparam int IMG_W = ROWS*COLS*8;
   localparam int ACC_W = DIV_BITS + 1;

   // Handshake: a transfer happens on a rising edge where valid && ready are both
   // high; ready and valid are decoded from the registered state only, and a
   // producer holds its payload stable while valid is high and ready is low.

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MAC  = 2'd1,
      DIV  = 2'd2,
      OUT  = 2'd3
   } state_t;

   state_t state, state_next;

   logic [IMG_W-1:0]        k_reg;
   logic [IMG_W-1:0]        w_reg;
   logic [7:0]              d_reg;
   logic signed [ACC_W-1:0] acc;
   logic                    neg;
   logic [DIV_BITS-1:0]     dvd;
   logic [7:0]              rem;
   logic [4:0]              cnt;
   logic [7:0]              pixel_reg;

   logic                    last_row;
   logic                    last_div;

   assign last_row = (cnt == 5'(ROWS-1));
   assign last_div = (cnt == 5'(DIV_BITS-1));

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (in_valid)  state_next = MAC;
         MAC:  if (last_row)  state_next = DIV;
         DIV:  if (last_div)  state_next = OUT;
         OUT:  if (out_ready) state_next = IDLE;
         default:             state_next = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state == IDLE);
      out_valid = (state == OUT);
   end

   assign out_pixel = pixel_reg;

   // ---------------------------------------------------------------- MAC row
   logic signed [7:0]       coef;
   logic [7:0]              pix;
   logic signed [16:0]      prod;
   logic signed [ACC_W-1:0] row_sum;
   logic signed [ACC_W-1:0] acc_next;
   logic [DIV_BITS-1:0]     mag;
   int                      base;

   always_comb begin
      row_sum = '0;
      coef    = '0;
      pix     = '0;
      prod    = '0;
      base    = 0;
      for (int c = 0; c < COLS; c++) begin
         base    = IMG_W - 1 - 8*(COLS*int'(cnt) + c);
         coef    = k_reg[base -: 8];
         pix     = w_reg[base -: 8];
         // Pixel is unsigned: zero-extend before the signed multiply.
         prod    = 17'(coef) * 17'($signed({1'b0, pix}));
         row_sum = row_sum + ACC_W'(prod);
      end
   end

   assign acc_next = acc + row_sum;
   assign mag      = acc_next[ACC_W-1] ? DIV_BITS'(-acc_next) : acc_next[DIV_BITS-1:0];

   // ---------------------------------------------------------------- divider step
   logic [7:0]          d_eff;
   logic [8:0]          trial;
   logic                qbit;
   logic [7:0]          rem_next;
   logic [DIV_BITS-1:0] quot;
   logic [7:0]          pix_result;

   always_comb begin
      d_eff    = (d_reg == 8'd0) ? 8'd1 : d_reg;
      trial    = {rem, dvd[DIV_BITS-1]};
      qbit     = (trial >= {1'b0, d_eff});
      rem_next = qbit ? 8'(trial - {1'b0, d_eff}) : trial[7:0];
      quot     = {dvd[DIV_BITS-2:0], qbit};
      if (neg)                       pix_result = 8'd0;
      else if (|quot[DIV_BITS-1:8])  pix_result = 8'd255;
      else                           pix_result = quot[7:0];
   end

   // ---------------------------------------------------------------- datapath
   always_ff @(posedge clk) begin
      if (reset) begin
         k_reg     <= '0;
         w_reg     <= '0;
         d_reg     <= '0;
         acc       <= '0;
         neg       <= 1'b0;
         dvd       <= '0;
         rem       <= '0;
         cnt       <= '0;
         pixel_reg <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  k_reg <= kernel;
                  w_reg <= window;
                  d_reg <= divisor;
                  acc   <= '0;
                  cnt   <= '0;
               end
            end
            MAC: begin
               acc <= acc_next;
               if (last_row) begin
                  // Only a strictly negative sum sets neg, so neg implies |acc| != 0.
                  neg <= acc_next[ACC_W-1];
                  dvd <= mag;
                  rem <= '0;
                  cnt <= '0;
               end else begin
                  cnt <= cnt + 5'd1;
               end
            end
            DIV: begin
               dvd <= quot;
               rem <= rem_next;
               if (last_div) begin
                  pixel_reg <= pix_result;
                  cnt       <= '0;
               end else begin
                  cnt <= cnt + 5'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_kernel_convolve.sv
// Self-checking bench for kernel_convolve: directed vector table, randomized
// windows against an arithmetic reference model, backpressure and reset corners.
`timescale 1ns/1ps

module tb_kernel_convolve;

   logic         clk = 1'b0;
   logic         reset;
   logic [391:0] kernel;
   logic [7:0]   divisor;
   logic [391:0] window;
   logic         in_valid;
   logic         in_ready;
   logic [7:0]   out_pixel;
   logic         out_valid;
   logic         out_ready;

   kernel_convolve dut (
      .clk       (clk),
      .reset     (reset),
      .kernel    (kernel),
      .divisor   (divisor),
      .window    (window),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_pixel (out_pixel),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   // ---------------------------------------------------------------- clock
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int         n_checks = 0;
   int         n_errors = 0;
   logic [7:0] exp_q[$];

   typedef struct {
      logic [391:0] k;
      logic [7:0]   d;
      logic [391:0] w;
      logic [7:0]   exp;
      string        name;
   } vec_t;

   vec_t vecs[12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // ---------------------------------------------------------------- helpers
   function automatic logic [391:0] fill(input logic [7:0] v);
      logic [391:0] b;
      for (int i = 0; i < 49; i++) b[391-8*i -: 8] = v;
      return b;
   endfunction

   function automatic logic [391:0] put(input logic [391:0] b, input int r, input int c,
                                        input logic [7:0] v);
      b[391-8*(7*r+c) -: 8] = v;
      return b;
   endfunction

   function automatic logic [391:0] rand_img(input int lo, input int hi);
      logic [391:0] b;
      for (int i = 0; i < 49; i++) b[391-8*i -: 8] = 8'($urandom_range(hi, lo));
      return b;
   endfunction

   // Reference: plain integer sum of products, floor division, clamp.
   function automatic logic [7:0] ref_pix(input logic [391:0] k, input logic [7:0] d,
                                          input logic [391:0] w);
      int                sum;
      int                dd;
      int                q;
      logic signed [7:0] kb;
      logic [7:0]        wb;
      sum = 0;
      for (int r = 0; r < 7; r++) begin
         for (int c = 0; c < 7; c++) begin
            kb  = k[391-8*(7*r+c) -: 8];
            wb  = w[391-8*(7*r+c) -: 8];
            sum = sum + int'(kb) * int'(wb);
         end
      end
      dd = (d == 8'd0) ? 1 : int'(d);
      if (sum < 0) return 8'd0;
      q = sum / dd;
      return (q > 255) ? 8'd255 : 8'(q);
   endfunction

   // ---------------------------------------------------------------- driver
   task automatic run_window(input logic [391:0] k, input logic [7:0] d, input logic [391:0] w,
                             input logic [7:0] exp, input int hold, input string name);
      int         n;
      bit         ok;
      bit         busy_bad;
      bit         hold_bad;
      logic [7:0] want;
      n = 0;
      while (in_ready !== 1'b1 && n < 60) begin
         @(negedge clk);
         n++;
      end
      check({name, " in_ready idle"}, 32'(in_ready), 32'd1);
      kernel   = k;
      divisor  = d;
      window   = w;
      in_valid = 1'b1;
      exp_q.push_back(exp);
      @(negedge clk);
      // Scramble the inputs: the captured window must not follow them.
      in_valid = 1'b0;
      kernel   = rand_img(0, 255);
      window   = rand_img(0, 255);
      divisor  = 8'($urandom_range(255, 0));
      n        = 0;
      ok       = 1'b0;
      busy_bad = 1'b0;
      while (n < 40) begin
         @(negedge clk);
         n++;
         if (out_valid === 1'b1) begin
            ok = 1'b1;
            break;
         end
         if (in_ready !== 1'b0) busy_bad = 1'b1;
      end
      check({name, " latency"}, ok ? 32'(n) : 32'd999, 32'd28);
      want = exp_q.pop_front();
      if (!ok) return;
      check({name, " pixel"}, 32'(out_pixel), 32'(want));
      check({name, " in_ready busy"}, 32'(busy_bad), 32'd0);
      hold_bad = 1'b0;
      for (int i = 0; i < hold; i++) begin
         out_ready = 1'b0;
         in_valid  = 1'b1;
         kernel    = rand_img(0, 255);
         window    = rand_img(0, 255);
         @(negedge clk);
         if (out_valid !== 1'b1 || out_pixel !== want || in_ready !== 1'b0) hold_bad = 1'b1;
      end
      if (hold > 0) check({name, " backpressure stable"}, 32'(hold_bad), 32'd0);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({name, " out_valid after hs"}, 32'(out_valid), 32'd0);
      check({name, " in_ready after hs"}, 32'(in_ready), 32'd1);
   endtask

   // ---------------------------------------------------------------- test
   logic [391:0] box;
   logic [391:0] sobel;
   logic [391:0] img;
   logic [391:0] img2;

   initial begin
      box   = fill(8'd0);
      sobel = fill(8'd0);
      for (int r = 2; r <= 4; r++)
         for (int c = 2; c <= 4; c++) box = put(box, r, c, 8'd1);
      sobel = put(sobel, 2, 2, 8'hFF);
      sobel = put(sobel, 2, 4, 8'h01);
      sobel = put(sobel, 3, 2, 8'hFE);
      sobel = put(sobel, 3, 4, 8'h02);
      sobel = put(sobel, 4, 2, 8'hFF);
      sobel = put(sobel, 4, 4, 8'h01);
      img  = fill(8'd0);
      img2 = fill(8'd0);
      for (int r = 0; r < 7; r++) begin
         for (int c = 0; c <= 2; c++) img  = put(img,  r, c, 8'd255);
         for (int c = 4; c <= 6; c++) img2 = put(img2, r, c, 8'd255);
      end

      vecs[0]  = '{put(fill(8'd0), 3, 3, 8'd1), 8'd1, put(fill(8'd7), 3, 3, 8'd200), 8'd200, "identity"};
      vecs[1]  = '{box, 8'd9, fill(8'd90), 8'd90, "box90"};
      vecs[2]  = '{box, 8'd9, fill(8'd200), 8'd1, "box17"};
      for (int r = 2; r <= 4; r++)
         for (int c = 2; c <= 4; c++) vecs[2].w = put(vecs[2].w, r, c, 8'd1);
      vecs[2].w = put(vecs[2].w, 3, 3, 8'd9);
      vecs[3]  = '{sobel, 8'd1, img,  8'd0,   "sobel_neg"};
      vecs[4]  = '{sobel, 8'd1, img2, 8'd255, "sobel_pos"};
      vecs[5]  = '{fill(8'h80), 8'd1, fill(8'd255), 8'd0,   "min_sum"};
      vecs[6]  = '{fill(8'h7F), 8'd0, fill(8'd255), 8'd255, "max_div0"};
      vecs[7]  = '{put(fill(8'd0), 3, 3, 8'd1), 8'd0, put(fill(8'd250), 3, 3, 8'd5), 8'd5, "centre_div0"};
      vecs[8]  = '{fill(8'h7F), 8'd200, fill(8'd1), 8'd31, "div200"};
      vecs[9]  = '{fill(8'd0), 8'd5, fill(8'd255), 8'd0, "zero_kernel"};
      vecs[10] = '{fill(8'd1), 8'd255, fill(8'd255), 8'd49, "exact255"};
      vecs[11] = '{fill(8'd1), 8'd246, fill(8'd5), 8'd0, "below_one"};

      // Reset state
      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      kernel    = '0;
      divisor   = '0;
      window    = '0;
      repeat (3) @(negedge clk);
      check("reset in_ready",  32'(in_ready),  32'd1);
      check("reset out_valid", 32'(out_valid), 32'd0);
      check("reset out_pixel", 32'(out_pixel), 32'd0);
      reset = 1'b0;
      @(negedge clk);

      // Directed table; vector 1 also exercises a 10-cycle backpressure hold
      for (int i = 0; i < 12; i++)
         run_window(vecs[i].k, vecs[i].d, vecs[i].w, vecs[i].exp, (i == 1) ? 10 : 0, vecs[i].name);

      // Reset in the middle of DIV abandons the window
      begin
         bit spurious;
         while (in_ready !== 1'b1) @(negedge clk);
         kernel   = vecs[0].k;
         divisor  = vecs[0].d;
         window   = vecs[0].w;
         in_valid = 1'b1;
         @(negedge clk);
         in_valid = 1'b0;
         repeat (12) @(negedge clk);
         reset = 1'b1;
         @(negedge clk);
         reset = 1'b0;
         check("midreset in_ready",  32'(in_ready),  32'd1);
         check("midreset out_valid", 32'(out_valid), 32'd0);
         check("midreset out_pixel", 32'(out_pixel), 32'd0);
         spurious = 1'b0;
         repeat (35) begin
            @(negedge clk);
            if (out_valid !== 1'b0) spurious = 1'b1;
         end
         check("midreset no output", 32'(spurious), 32'd0);
         run_window(vecs[1].k, vecs[1].d, vecs[1].w, vecs[1].exp, 0, "after_reset");
      end

      // Randomized windows, back-to-back, against the reference model
      for (int i = 0; i < 20; i++) begin
         logic [391:0] rk;
         logic [391:0] rw;
         logic [7:0]   rd;
         rk = (i % 2 == 0) ? rand_img(0, 255) : fill(8'd0);
         if (i % 2 == 1)
            for (int j = 0; j < 49; j++) rk[391-8*j -: 8] = 8'(int'($urandom_range(16, 0)) - 4);
         rw = rand_img(0, 255);
         rd = 8'($urandom_range(255, 0));
         run_window(rk, rd, rw, ref_pix(rk, rd, rw), int'($urandom_range(3, 0)),
                    $sformatf("rand%0d", i));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
